// File: rtl/spi_master.sv
// SPI mode-0 master: one 16-bit {rw, addr[6:0], data} register-access frame per accepted start.
// Latency: done pulses 33*CLK_DIV cycles after accept; busy drops CLK_DIV cycles after done.
// Backpressure: start is only sampled while idle; requests arriving during a frame are dropped.
module spi_master #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       nss,
    output logic       sck,
    output logic       mosi,
    input  logic       miso
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SCK_HI,
        S_SCK_LO,
        S_HOLD,
        S_GAP
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  div_cnt, div_cnt_nxt;
    logic [3:0]  bit_cnt, bit_cnt_nxt;
    logic [15:0] tx_sr, tx_sr_nxt;
    logic [15:0] rx_sr, rx_sr_nxt;
    logic        is_read, is_read_nxt;
    logic        busy_q, busy_nxt;
    logic        done_q, done_nxt;
    logic [7:0]  rdata_q, rdata_nxt;
    logic        nss_q, nss_nxt;
    logic        sck_q, sck_nxt;
    logic        mosi_q, mosi_nxt;
    logic        phase_end;

    // Every non-idle state lasts exactly one sck half-period.
    assign phase_end = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            div_cnt <= 8'd0;
            bit_cnt <= 4'd0;
            tx_sr   <= 16'h0000;
            rx_sr   <= 16'h0000;
            is_read <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= 8'h00;
            nss_q   <= 1'b1;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            div_cnt <= div_cnt_nxt;
            bit_cnt <= bit_cnt_nxt;
            tx_sr   <= tx_sr_nxt;
            rx_sr   <= rx_sr_nxt;
            is_read <= is_read_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
            rdata_q <= rdata_nxt;
            nss_q   <= nss_nxt;
            sck_q   <= sck_nxt;
            mosi_q  <= mosi_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        div_cnt_nxt = div_cnt + 8'd1;
        bit_cnt_nxt = bit_cnt;
        tx_sr_nxt   = tx_sr;
        rx_sr_nxt   = rx_sr;
        is_read_nxt = is_read;
        busy_nxt    = busy_q;
        done_nxt    = 1'b0;
        rdata_nxt   = rdata_q;
        nss_nxt     = nss_q;
        sck_nxt     = sck_q;
        mosi_nxt    = mosi_q;

        unique case (state)
            S_IDLE: begin
                div_cnt_nxt = 8'd0;
                if (start) begin
                    // Reads send a zero data byte; the rw bit is also the frame MSB.
                    tx_sr_nxt   = rw ? {1'b1, addr, 8'h00} : {1'b0, addr, wdata};
                    is_read_nxt = rw;
                    mosi_nxt    = rw;
                    bit_cnt_nxt = 4'd0;
                    nss_nxt     = 1'b0;
                    busy_nxt    = 1'b1;
                    state_nxt   = S_SETUP;
                end
            end

            S_SETUP: begin
                if (phase_end) begin
                    div_cnt_nxt = 8'd0;
                    sck_nxt     = 1'b1;
                    rx_sr_nxt   = {rx_sr[14:0], miso};
                    state_nxt   = S_SCK_HI;
                end
            end

            S_SCK_HI: begin
                if (phase_end) begin
                    div_cnt_nxt = 8'd0;
                    sck_nxt     = 1'b0;
                    bit_cnt_nxt = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd15) begin
                        mosi_nxt  = 1'b0;
                        state_nxt = S_HOLD;
                    end else begin
                        tx_sr_nxt = {tx_sr[14:0], 1'b0};
                        mosi_nxt  = tx_sr[14];
                        state_nxt = S_SCK_LO;
                    end
                end
            end

            S_SCK_LO: begin
                if (phase_end) begin
                    div_cnt_nxt = 8'd0;
                    sck_nxt     = 1'b1;
                    rx_sr_nxt   = {rx_sr[14:0], miso};
                    state_nxt   = S_SCK_HI;
                end
            end

            S_HOLD: begin
                if (phase_end) begin
                    div_cnt_nxt = 8'd0;
                    nss_nxt     = 1'b1;
                    done_nxt    = 1'b1;
                    // Only the second byte carries register data; the first is discarded.
                    if (is_read) begin
                        rdata_nxt = rx_sr[7:0];
                    end
                    state_nxt = S_GAP;
                end
            end

            S_GAP: begin
                if (phase_end) begin
                    div_cnt_nxt = 8'd0;
                    busy_nxt    = 1'b0;
                    state_nxt   = S_IDLE;
                end
            end

            default: begin
                div_cnt_nxt = 8'd0;
                state_nxt   = S_IDLE;
            end
        endcase
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign rdata = rdata_q;
    assign nss   = nss_q;
    assign sck   = sck_q;
    assign mosi  = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: three instances (CLK_DIV 2, 1, 255) muxed onto one monitor and slave model.
// Expected frames, timings and read data come from the frame rules, not from the DUT.
module tb_spi_master;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] addr = 7'h00;
    logic [7:0] wdata = 8'h00;
    logic       miso;
    int         sel = 0;

    logic       start_w [3];
    logic       busy_w  [3];
    logic       done_w  [3];
    logic       nss_w   [3];
    logic       sck_w   [3];
    logic       mosi_w  [3];
    logic [7:0] rdata_w [3];

    logic       busy, done, nss, sck, mosi;
    logic [7:0] rdata;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign start_w[0] = start && (sel == 0);
    assign start_w[1] = start && (sel == 1);
    assign start_w[2] = start && (sel == 2);

    assign busy  = busy_w[sel];
    assign done  = done_w[sel];
    assign nss   = nss_w[sel];
    assign sck   = sck_w[sel];
    assign mosi  = mosi_w[sel];
    assign rdata = rdata_w[sel];

    spi_master #(.CLK_DIV(2)) u_dut_h2 (
        .clk(clk), .reset_n(reset_n), .start(start_w[0]), .rw(rw), .addr(addr), .wdata(wdata),
        .busy(busy_w[0]), .done(done_w[0]), .rdata(rdata_w[0]), .nss(nss_w[0]), .sck(sck_w[0]),
        .mosi(mosi_w[0]), .miso(miso)
    );
    spi_master #(.CLK_DIV(1)) u_dut_h1 (
        .clk(clk), .reset_n(reset_n), .start(start_w[1]), .rw(rw), .addr(addr), .wdata(wdata),
        .busy(busy_w[1]), .done(done_w[1]), .rdata(rdata_w[1]), .nss(nss_w[1]), .sck(sck_w[1]),
        .mosi(mosi_w[1]), .miso(miso)
    );
    spi_master #(.CLK_DIV(255)) u_dut_h255 (
        .clk(clk), .reset_n(reset_n), .start(start_w[2]), .rw(rw), .addr(addr), .wdata(wdata),
        .busy(busy_w[2]), .done(done_w[2]), .rdata(rdata_w[2]), .nss(nss_w[2]), .sck(sck_w[2]),
        .mosi(mosi_w[2]), .miso(miso)
    );

    // Mode-0 slave: presents bit 15 when selected, advances on each falling sck.
    logic [15:0] slave_word = 16'h0000;
    int          s_falls = 0;
    logic        s_psck = 1'b0;
    always @(negedge clk) begin
        if (nss !== 1'b0) s_falls = 0;
        else if (s_psck === 1'b1 && sck === 1'b0) s_falls++;
        s_psck = sck;
        miso = (nss === 1'b0 && s_falls < 16) ? slave_word[15 - s_falls] : 1'b0;
    end

    // Pin monitor: edge timestamps in clk-edge numbers.
    int   rise_cyc[$], fall_cyc[$], nss_fall[$], nss_rise[$], done_cyc[$], busy_fall[$];
    logic rise_mosi[$];
    logic [7:0] done_rd[$];
    int   clr_req = 0, clr_ack = 0;
    logic p_sck = 1'b0, p_nss = 1'b1, p_busy = 1'b0;
    always @(negedge clk) begin
        if (clr_req != clr_ack) begin
            rise_cyc.delete(); fall_cyc.delete(); nss_fall.delete(); nss_rise.delete();
            done_cyc.delete(); busy_fall.delete(); rise_mosi.delete(); done_rd.delete();
            clr_ack = clr_req;
        end
        if (sck === 1'b1 && p_sck === 1'b0) begin rise_cyc.push_back(cyc); rise_mosi.push_back(mosi); end
        if (sck === 1'b0 && p_sck === 1'b1) fall_cyc.push_back(cyc);
        if (nss === 1'b0 && p_nss === 1'b1) nss_fall.push_back(cyc);
        if (nss === 1'b1 && p_nss === 1'b0) nss_rise.push_back(cyc);
        if (done === 1'b1) begin done_cyc.push_back(cyc); done_rd.push_back(rdata); end
        if (busy === 1'b0 && p_busy === 1'b1) busy_fall.push_back(cyc);
        p_sck = sck; p_nss = nss; p_busy = busy;
    end

    function automatic logic [15:0] exp_word(logic r, logic [6:0] a, logic [7:0] d);
        return r ? {1'b1, a, 8'h00} : {1'b0, a, d};
    endfunction

    function automatic logic [15:0] frame_word(int f);
        logic [15:0] w = 16'h0000;
        if (rise_mosi.size() < 16 * (f + 1)) return 16'hxxxx;
        for (int i = 0; i < 16; i++) w = {w[14:0], rise_mosi[16 * f + i]};
        return w;
    endfunction

    // Counts sck edges that miss the ideal schedule: rise k at acc+(2k-1)H, fall k at acc+2kH.
    function automatic int timing_errs(int f, int acc, int h);
        int e = 0;
        if (rise_cyc.size() < 16 * (f + 1) || fall_cyc.size() < 16 * (f + 1)) return 99;
        for (int k = 1; k <= 16; k++) begin
            if (rise_cyc[16 * f + k - 1] != acc + (2 * k - 1) * h) e++;
            if (fall_cyc[16 * f + k - 1] != acc + 2 * k * h) e++;
        end
        return e;
    endfunction

    task automatic clear_mon();
        clr_req++;
        @(negedge clk);
    endtask

    task automatic do_accept(int s, logic r, logic [6:0] a, logic [7:0] d, logic [15:0] sw,
                             output int acc);
        sel = s; rw = r; addr = a; wdata = d; slave_word = sw;
        start = 1'b1;
        acc = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(int n, int budget);
        int w = 0;
        while (done_cyc.size() < n && w < budget) begin @(negedge clk); w++; end
        checks++;
        if (done_cyc.size() < n) begin
            errors++;
            $display("FAIL done_timeout: got %0d done pulses, need %0d", done_cyc.size(), n);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({nss_w[k], sck_w[k], mosi_w[k], busy_w[k], done_w[k], rdata_w[k]} !== {5'b10000, 8'h00}) begin
                errors++;
                $display("FAIL reset_state[%0d]: got nss/sck/mosi/busy/done=%b%b%b%b%b rdata=%h, need 10000 rdata=00",
                         k, nss_w[k], sck_w[k], mosi_w[k], busy_w[k], done_w[k], rdata_w[k]);
            end
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write();
        int acc;
        clear_mon();
        do_accept(0, 1'b0, 7'h05, 8'hA5, 16'hFFFF, acc);
        wait_done(1, 200);
        repeat (6) @(negedge clk);
        checks++; if (frame_word(0) !== exp_word(1'b0, 7'h05, 8'hA5)) begin errors++;
            $display("FAIL write_mosi: got %h, need %h", frame_word(0), exp_word(1'b0, 7'h05, 8'hA5)); end
        checks++; if (rise_cyc.size() != 16) begin errors++;
            $display("FAIL write_pulses: got %0d, need 16", rise_cyc.size()); end
        checks++; if (timing_errs(0, acc, 2) != 0) begin errors++;
            $display("FAIL write_sck_timing: got %0d misplaced edges, need 0", timing_errs(0, acc, 2)); end
        checks++; if (nss_fall.size() != 1 || nss_rise.size() != 1 || nss_fall[0] != acc || nss_rise[0] - nss_fall[0] != 66) begin
            errors++; $display("FAIL write_nss_low: got %0d falls %0d rises, need one 66-cycle low", nss_fall.size(), nss_rise.size()); end
        checks++; if (done_cyc.size() != 1 || done_cyc[0] != acc + 66) begin errors++;
            $display("FAIL write_done_edge: got %0d pulses, first at +%0d, need one at +66", done_cyc.size(),
                     done_cyc.size() > 0 ? done_cyc[0] - acc : -1); end
        checks++; if (busy_fall.size() != 1 || busy_fall[0] != acc + 68) begin errors++;
            $display("FAIL write_busy_fall: got %0d falls, need one at +68", busy_fall.size()); end
        checks++; if (rdata !== 8'h00) begin errors++;
            $display("FAIL write_rdata: got %h, need 00", rdata); end
    endtask

    task automatic test_read();
        int acc;
        clear_mon();
        do_accept(0, 1'b1, 7'h7F, 8'h5A, 16'hFF3C, acc);
        wait_done(1, 200);
        repeat (6) @(negedge clk);
        checks++; if (frame_word(0) !== 16'hFF00) begin errors++;
            $display("FAIL read_mosi: got %h, need ff00", frame_word(0)); end
        checks++; if (done_rd.size() != 1 || done_rd[0] !== 8'h3C) begin errors++;
            $display("FAIL read_rdata_at_done: got %0d pulses, need one with rdata=3c", done_rd.size()); end
        checks++; if (timing_errs(0, acc, 2) != 0) begin errors++;
            $display("FAIL read_sck_timing: got %0d misplaced edges, need 0", timing_errs(0, acc, 2)); end
        checks++; if (rdata !== 8'h3C) begin errors++;
            $display("FAIL read_rdata_hold: got %h, need 3c", rdata); end
    endtask

    task automatic test_back_to_back();
        int acc0;
        logic [6:0] a;
        logic [7:0] d;
        clear_mon();
        a = 7'($urandom); d = 8'($urandom);
        sel = 1; rw = 1'b0; addr = a; wdata = d; slave_word = 16'h0000;
        start = 1'b1;
        acc0 = cyc + 1;
        wait_done(3, 300);
        start = 1'b0;
        repeat (60) @(negedge clk);
        checks++; if (done_cyc.size() != 3) begin errors++;
            $display("FAIL b2b_done_count: got %0d, need 3", done_cyc.size()); end
        checks++; if (rise_cyc.size() != 48) begin errors++;
            $display("FAIL b2b_pulses: got %0d, need 48", rise_cyc.size()); end
        if (done_cyc.size() == 3 && nss_fall.size() == 3 && nss_rise.size() == 3) begin
            for (int f = 0; f < 3; f++) begin
                checks++; if (done_cyc[f] != acc0 + 35 * f + 33) begin errors++;
                    $display("FAIL b2b_done_edge[%0d]: got +%0d, need +%0d", f, done_cyc[f] - acc0, 35 * f + 33); end
                checks++; if (nss_rise[f] - nss_fall[f] != 33) begin errors++;
                    $display("FAIL b2b_nss_low[%0d]: got %0d, need 33", f, nss_rise[f] - nss_fall[f]); end
                checks++; if (frame_word(f) !== exp_word(1'b0, a, d)) begin errors++;
                    $display("FAIL b2b_mosi[%0d]: got %h, need %h", f, frame_word(f), exp_word(1'b0, a, d)); end
                checks++; if (timing_errs(f, acc0 + 35 * f, 1) != 0) begin errors++;
                    $display("FAIL b2b_sck_timing[%0d]: got %0d misplaced edges", f, timing_errs(f, acc0 + 35 * f, 1)); end
                if (f < 2) begin
                    checks++; if (nss_fall[f + 1] - nss_rise[f] != 2) begin errors++;
                        $display("FAIL b2b_nss_gap[%0d]: got %0d, need 2", f, nss_fall[f + 1] - nss_rise[f]); end
                end
            end
        end
    endtask

    task automatic test_busy_protect();
        int acc;
        int pulse_at [2] = '{3, 20};
        clear_mon();
        do_accept(0, 1'b0, 7'h12, 8'h34, 16'h0000, acc);
        for (int p = 0; p < 2; p++) begin
            while (cyc < acc + pulse_at[p] - 1) @(negedge clk);
            rw = 1'($urandom); addr = 7'h12 ^ 7'($urandom_range(1, 127)); wdata = 8'h34 ^ 8'($urandom_range(1, 255));
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done(1, 200);
        repeat (40) @(negedge clk);
        checks++; if (frame_word(0) !== 16'h1234) begin errors++;
            $display("FAIL busy_mosi: got %h, need 1234", frame_word(0)); end
        checks++; if (done_cyc.size() != 1 || nss_fall.size() != 1) begin errors++;
            $display("FAIL busy_single_frame: got %0d done %0d frames, need 1 and 1", done_cyc.size(), nss_fall.size()); end
    endtask

    task automatic test_reset_mid();
        int acc;
        clear_mon();
        do_accept(0, 1'b1, 7'($urandom), 8'h00, 16'($urandom), acc);
        while (cyc < acc + 9 * 2 + 1) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++; if (rise_cyc.size() != 5) begin errors++;
            $display("FAIL rstmid_pulses_before: got %0d, need 5", rise_cyc.size()); end
        checks++; if ({nss, sck, mosi, busy, done, rdata} !== {5'b10000, 8'h00}) begin errors++;
            $display("FAIL rstmid_outputs: got nss/sck/mosi/busy/done=%b%b%b%b%b rdata=%h, need 10000 rdata=00",
                     nss, sck, mosi, busy, done, rdata); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (100) @(negedge clk);
        checks++; if (done_cyc.size() != 0) begin errors++;
            $display("FAIL rstmid_no_done: got %0d, need 0", done_cyc.size()); end
        clear_mon();
        do_accept(0, 1'b0, 7'h01, 8'h02, 16'h0000, acc);
        wait_done(1, 200);
        repeat (6) @(negedge clk);
        checks++; if (frame_word(0) !== 16'h0102 || done_cyc[0] != acc + 66) begin errors++;
            $display("FAIL rstmid_recover: got %h, need 0102 done at +66", frame_word(0)); end
    endtask

    task automatic test_divider();
        int acc, h;
        logic [6:0] a;
        logic [7:0] d;
        for (int s = 1; s <= 2; s++) begin
            h = (s == 1) ? 1 : 255;
            a = 7'($urandom); d = 8'($urandom);
            clear_mon();
            do_accept(s, 1'b0, a, d, 16'h0000, acc);
            wait_done(1, 40 * h + 50);
            repeat (h + 4) @(negedge clk);
            checks++; if (rise_cyc.size() != 16 || fall_cyc.size() != 16) begin errors++;
                $display("FAIL div%0d_pulses: got %0d rises %0d falls, need 16", h, rise_cyc.size(), fall_cyc.size()); end
            checks++; if (timing_errs(0, acc, h) != 0) begin errors++;
                $display("FAIL div%0d_half_period: got %0d misplaced edges, need 0", h, timing_errs(0, acc, h)); end
            checks++; if (done_cyc.size() != 1 || done_cyc[0] != acc + 33 * h) begin errors++;
                $display("FAIL div%0d_done_edge: got %0d pulses, need one at +%0d", h, done_cyc.size(), 33 * h); end
            checks++; if (frame_word(0) !== exp_word(1'b0, a, d)) begin errors++;
                $display("FAIL div%0d_mosi: got %h, need %h", h, frame_word(0), exp_word(1'b0, a, d)); end
        end
    endtask

    task automatic test_random();
        int acc;
        logic r;
        logic [6:0] a;
        logic [7:0] d, exp_rd;
        logic [15:0] sw;
        exp_rd = 8'h00;
        for (int n = 0; n < 8; n++) begin
            r = 1'($urandom); a = 7'($urandom); d = 8'($urandom); sw = 16'($urandom);
            if (r) exp_rd = sw[7:0];
            clear_mon();
            do_accept(0, r, a, d, sw, acc);
            wait_done(1, 200);
            repeat (6) @(negedge clk);
            checks++; if (frame_word(0) !== exp_word(r, a, d)) begin errors++;
                $display("FAIL rand%0d_mosi: got %h, need %h", n, frame_word(0), exp_word(r, a, d)); end
            checks++; if (done_rd.size() != 1 || done_rd[0] !== exp_rd || rdata !== exp_rd) begin errors++;
                $display("FAIL rand%0d_rdata: got %h, need %h", n, rdata, exp_rd); end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_busy_protect();
        test_reset_mid();
        test_divider();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
